video_coord_tracker: RTL and testbench
======================================

# video_coord_tracker

Upstream stage of the image-processing IP. It accepts the AXI4-Stream video feed and passes it through unchanged via a skid buffer, while producing per-pixel column/row coordinates, a pixel strobe, and frame boundary pulses. It drives the laser detector's `pixel_col`, `pixel_row`, `en` and `data` inputs. `frame_start` lets the detector re-arm every frame.

## Interface
Parameters:
- `ACTIVE_COLS`, 640, expected beats per line
- `ACTIVE_ROWS`, 480, expected lines per frame

Ports (clock and reset first):
- `clk`  in  1  clock
- `reset_n`  in  1  reset, synchronous, active-low
- `s_axis_tdata`  in  `PIXEL_SIZE`  pixel, {R,B,G} = [23:16],[15:8],[7:0]
- `s_axis_tvalid`  in  1  input beat valid
- `s_axis_tready`  out  1  input ready
- `s_axis_tuser`  in  1  start of frame (first pixel)
- `s_axis_tlast`  in  1  end of line
- `m_axis_tdata/tvalid/tuser/tlast`  out  `PIXEL_SIZE`/1/1/1  pass-through stream
- `m_axis_tready`  in  1  downstream ready
- `pix_en`  out  1  one-cycle strobe per in-frame accepted beat
- `pix_col`  out  16  column of strobed beat
- `pix_row`  out  16  row of strobed beat
- `pix_data`  out  `PIXEL_SIZE`  data of strobed beat
- `frame_start`  out  1  pulse on accepted SOF beat
- `frame_done`  out  1  pulse on accepted final EOL beat
- `err_flags`  out  3  sticky {sof_midframe, line_long, line_short}
- `clear_err`  in  1  clears `err_flags`

## Operation
- Accepted beat = `s_axis_tvalid & s_axis_tready`. All counting happens on accepted beats only.
- States:
  - WAIT_SOF: beats without tuser pass through with `pix_en`=0.
  - ACTIVE: normal counting.
  - Transitions:
    - tuser beat: col=0, row=0, go to ACTIVE.
    - tlast with row==`ACTIVE_ROWS`-1: go to WAIT_SOF.
- In ACTIVE, each beat emits `pix_en` with the current col/row, then col increments.
  - On tlast, col goes to 0 and row increments.
  - col saturates at 0xFFFF.
- `line_short`: set when tlast arrives with col < `ACTIVE_COLS`-1. The row still advances.
- `line_long`: set when a beat is accepted with col >= `ACTIVE_COLS`. The beat is still strobed with its true col.
- `sof_midframe`: set when tuser arrives in ACTIVE with (col,row) != (0,0).
  - Restart at (0,0) and pulse `frame_start`.
  - No `frame_done` for the aborted frame.
- tuser and tlast on the same beat: process SOF first, then EOL (pixel at (0,0), next row 1).
- If `ACTIVE_ROWS`==1, that beat also gives `frame_done`.
- `clear_err` zeroes the flags. If a new error occurs in the same cycle, the error wins.
- Pass-through path: 2-entry skid buffer. Data and sideband are never modified, dropped or reordered.
- Reset values:
  - State WAIT_SOF, col=row=0.
  - `pix_en`, `frame_start`, `frame_done`, `err_flags`, `m_axis_tvalid` = 0.
  - `pix_col`, `pix_row`, `pix_data` = 0.
  - `s_axis_tready`=0 during reset, 1 on the first cycle after reset.
- Reset mid-frame: all contents are discarded. The block returns to WAIT_SOF and ignores beats until the next tuser.

## Timing
- `pix_en`/`pix_col`/`pix_row`/`pix_data`/`frame_start`/`frame_done` are registered, asserted the cycle after acceptance.
  - `frame_start` coincides with the (0,0) `pix_en`.
  - `frame_done` coincides with the last pixel's `pix_en`.
- `s_axis_tready` is a register: high while the skid entry is empty.
- Input-to-`m_axis` latency: 1 cycle. Full throughput of 1 beat/clk while `m_axis_tready`=1.
- With `m_axis_tready` held low:
  - At most 2 beats are accepted.
  - `s_axis_tready` falls the cycle after the second beat is accepted.
- `m_axis_tvalid` stays high until handshaked, and `m_axis` payload is stable while tvalid & !tready (AXI rule).
- Coordinate outputs are independent of `m_axis_tready` except through input backpressure.

## Structure
- Shared package/header:
  - `PIXEL_SIZE` (from global.vh)
  - State encodings WAIT_SOF/ACTIVE
  - Error bit indices ERR_SHORT=0, ERR_LONG=1, ERR_SOF=2
- Sub-module `axis_skid_buffer`: parameter WIDTH, carries {tuser, tlast, tdata}. Reusable across the IP.
- Top level holds the FSM, counters and error logic.

## Test plan
- 4x3 frame (ACTIVE_COLS=4, ACTIVE_ROWS=3), continuous valid, tready=1 → 12 `pix_en` with (col,row) (0,0)…(3,2); `frame_start` with the first, `frame_done` with the 12th; `err_flags`=0; `m_axis` identical to input at 1-cycle latency.
- 5 beats without tuser, then a valid frame → no `pix_en` for the first 5; strobes start at the SOF beat with (0,0).
- Line 1 ends with tlast at col 2, then the next line has 5 beats → `err_flags`=3'b011; row advances to 2 after each tlast; `frame_done` on row 2's tlast.
- tuser at (2,1) → `err_flags[2]`=1, `frame_start` pulse, strobe at (0,0); no `frame_done`; `clear_err` then returns the flags to 0.
- Random `m_axis_tready` (50%) and random tvalid over 3 frames → output beat sequence equals input; never more than 2 beats held; coordinates match the golden model.
- `reset_n` low for 1 cycle mid-line → all outputs return to reset values; beats are ignored until the next tuser.

Source files
------------

// File: rtl/video_coord_tracker_pkg.sv
// Shared definitions for the video coordinate tracker: pixel width, FSM
// state encoding and error-flag bit positions.
package video_coord_tracker_pkg;

  localparam int PIXEL_SIZE = 24;
  localparam int COORD_W    = 16;

  typedef enum logic {
    WAIT_SOF = 1'b0,
    ACTIVE   = 1'b1
  } state_t;

  localparam int ERR_SHORT = 0;
  localparam int ERR_LONG  = 1;
  localparam int ERR_SOF   = 2;

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry AXI4-Stream skid buffer: a registered output stage plus one skid
// slot, with a registered ready that drops only once the skid slot is full.
module axis_skid_buffer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] i_s_data,
  input  logic             i_s_valid,
  output logic             o_s_ready,
  output logic [WIDTH-1:0] o_m_data,
  output logic             o_m_valid,
  input  logic             i_m_ready
);

  logic [WIDTH-1:0] r_out_data;
  logic [WIDTH-1:0] r_skid_data;
  logic             r_out_valid;
  logic             r_skid_valid;
  logic             r_ready;
  logic             w_in_acc;
  logic             w_out_free;

  assign w_in_acc   = i_s_valid & r_ready;
  assign w_out_free = ~r_out_valid | i_m_ready;

  // Control stage: valids and registered ready are the only reset state
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
      r_ready      <= 1'b0;
    end else if (w_out_free) begin
      r_out_valid  <= r_skid_valid | w_in_acc;
      r_skid_valid <= 1'b0;
      r_ready      <= 1'b1;
    end else if (w_in_acc) begin
      r_skid_valid <= 1'b1;
      r_ready      <= 1'b0;
    end
  end

  // Data stage: skid contents drain first so ordering is preserved
  always_ff @(posedge clk) begin
    if (w_out_free) begin
      if (r_skid_valid) begin
        r_out_data <= r_skid_data;
      end else if (w_in_acc) begin
        r_out_data <= i_s_data;
      end
    end
    if (!w_out_free && w_in_acc) begin
      r_skid_data <= i_s_data;
    end
  end

  assign o_s_ready = r_ready;
  assign o_m_data  = r_out_data;
  assign o_m_valid = r_out_valid;

endmodule

// File: rtl/video_coord_tracker.sv
// Passes the AXI4-Stream video feed through a skid buffer and tracks the
// column/row of every in-frame beat, with frame pulses and sticky errors.
module video_coord_tracker
  import video_coord_tracker_pkg::*;
#(
  parameter int ACTIVE_COLS = 640,
  parameter int ACTIVE_ROWS = 480
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [PIXEL_SIZE-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tuser,
  input  logic                  s_axis_tlast,
  output logic [PIXEL_SIZE-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tuser,
  output logic                  m_axis_tlast,
  input  logic                  m_axis_tready,
  output logic                  pix_en,
  output logic [COORD_W-1:0]    pix_col,
  output logic [COORD_W-1:0]    pix_row,
  output logic [PIXEL_SIZE-1:0] pix_data,
  output logic                  frame_start,
  output logic                  frame_done,
  output logic [2:0]            err_flags,
  input  logic                  clear_err
);

  localparam logic [COORD_W-1:0] LP_COLS    = COORD_W'(ACTIVE_COLS);
  localparam logic [COORD_W-1:0] LP_COLS_M1 = COORD_W'(ACTIVE_COLS - 1);
  localparam logic [COORD_W-1:0] LP_ROWS_M1 = COORD_W'(ACTIVE_ROWS - 1);

  state_t                r_state;
  logic [COORD_W-1:0]    r_col;
  logic [COORD_W-1:0]    r_row;
  logic                  r_pix_en_p1;
  logic [COORD_W-1:0]    r_pix_col_p1;
  logic [COORD_W-1:0]    r_pix_row_p1;
  logic [PIXEL_SIZE-1:0] r_pix_data_p1;
  logic                  r_frame_start_p1;
  logic                  r_frame_done_p1;
  logic [2:0]            r_err;

  logic                  w_acc;
  logic                  w_counting;
  logic [COORD_W-1:0]    w_col_eff;
  logic [COORD_W-1:0]    w_row_eff;
  logic                  w_last_row;
  logic [2:0]            w_err_new;
  logic [PIXEL_SIZE+1:0] w_skid_in;
  logic [PIXEL_SIZE+1:0] w_skid_out;

  function automatic logic [COORD_W-1:0] sat_inc(input logic [COORD_W-1:0] v);
    return (v == {COORD_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  assign w_skid_in = {s_axis_tuser, s_axis_tlast, s_axis_tdata};

  axis_skid_buffer #(
    .WIDTH (PIXEL_SIZE + 2)
  ) u_skid (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_s_data  (w_skid_in),
    .i_s_valid (s_axis_tvalid),
    .o_s_ready (s_axis_tready),
    .o_m_data  (w_skid_out),
    .o_m_valid (m_axis_tvalid),
    .i_m_ready (m_axis_tready)
  );

  assign m_axis_tuser = w_skid_out[PIXEL_SIZE+1];
  assign m_axis_tlast = w_skid_out[PIXEL_SIZE];
  assign m_axis_tdata = w_skid_out[PIXEL_SIZE-1:0];

  // An SOF beat restarts the coordinates before the beat itself is counted
  always_comb begin
    w_acc      = s_axis_tvalid & s_axis_tready;
    w_counting = w_acc & (s_axis_tuser | (r_state == ACTIVE));
    w_col_eff  = s_axis_tuser ? '0 : r_col;
    w_row_eff  = s_axis_tuser ? '0 : r_row;
    w_last_row = (w_row_eff == LP_ROWS_M1);
    w_err_new  = '0;
    w_err_new[ERR_SOF]   = w_acc & s_axis_tuser & (r_state == ACTIVE) &
                           ((r_col != '0) | (r_row != '0));
    w_err_new[ERR_LONG]  = w_counting & (w_col_eff >= LP_COLS);
    w_err_new[ERR_SHORT] = w_counting & s_axis_tlast & (w_col_eff < LP_COLS_M1);
  end

  // Stage p1: registered strobe, coordinates and frame pulses
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state          <= WAIT_SOF;
      r_col            <= '0;
      r_row            <= '0;
      r_pix_en_p1      <= 1'b0;
      r_pix_col_p1     <= '0;
      r_pix_row_p1     <= '0;
      r_pix_data_p1    <= '0;
      r_frame_start_p1 <= 1'b0;
      r_frame_done_p1  <= 1'b0;
      r_err            <= '0;
    end else begin
      r_pix_en_p1      <= w_counting;
      r_frame_start_p1 <= w_counting & s_axis_tuser;
      r_frame_done_p1  <= w_counting & s_axis_tlast & w_last_row;
      r_err            <= clear_err ? w_err_new : (r_err | w_err_new);
      if (w_counting) begin
        r_pix_col_p1  <= w_col_eff;
        r_pix_row_p1  <= w_row_eff;
        r_pix_data_p1 <= s_axis_tdata;
        if (s_axis_tlast) begin
          r_col <= '0;
          if (w_last_row) begin
            r_state <= WAIT_SOF;
            r_row   <= '0;
          end else begin
            r_state <= ACTIVE;
            r_row   <= sat_inc(w_row_eff);
          end
        end else begin
          r_state <= ACTIVE;
          r_col   <= sat_inc(w_col_eff);
          r_row   <= w_row_eff;
        end
      end
    end
  end

  assign pix_en      = r_pix_en_p1;
  assign pix_col     = r_pix_col_p1;
  assign pix_row     = r_pix_row_p1;
  assign pix_data    = r_pix_data_p1;
  assign frame_start = r_frame_start_p1;
  assign frame_done  = r_frame_done_p1;
  assign err_flags   = r_err;

endmodule

// File: tb/tb_video_coord_tracker.sv
// Scoreboard bench for video_coord_tracker on a 4x3 frame: a driver pushes
// expected pixels and stream beats, a monitor pops and compares them.
module tb_video_coord_tracker;
  import video_coord_tracker_pkg::*;

  localparam int COLS = 4;
  localparam int ROWS = 3;

  logic                  clk = 1'b0;
  logic                  reset_n = 1'b0;
  logic [PIXEL_SIZE-1:0] s_axis_tdata = '0;
  logic                  s_axis_tvalid = 1'b0;
  logic                  s_axis_tready;
  logic                  s_axis_tuser = 1'b0;
  logic                  s_axis_tlast = 1'b0;
  logic [PIXEL_SIZE-1:0] m_axis_tdata;
  logic                  m_axis_tvalid;
  logic                  m_axis_tuser;
  logic                  m_axis_tlast;
  logic                  m_axis_tready = 1'b1;
  logic                  pix_en;
  logic [15:0]           pix_col;
  logic [15:0]           pix_row;
  logic [PIXEL_SIZE-1:0] pix_data;
  logic                  frame_start;
  logic                  frame_done;
  logic [2:0]            err_flags;
  logic                  clear_err = 1'b0;

  always #5 clk = ~clk;

  video_coord_tracker #(.ACTIVE_COLS(COLS), .ACTIVE_ROWS(ROWS)) dut (
    .clk(clk), .reset_n(reset_n),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready), .s_axis_tuser(s_axis_tuser),
    .s_axis_tlast(s_axis_tlast),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tuser(m_axis_tuser), .m_axis_tlast(m_axis_tlast),
    .m_axis_tready(m_axis_tready),
    .pix_en(pix_en), .pix_col(pix_col), .pix_row(pix_row), .pix_data(pix_data),
    .frame_start(frame_start), .frame_done(frame_done),
    .err_flags(err_flags), .clear_err(clear_err)
  );

  typedef struct {
    int              col;
    int              row;
    logic [23:0]     d;
    bit              fs;
    bit              fd;
    int              cyc;
  } pexp_t;

  typedef struct {
    logic [25:0] v;
    int          cyc;
    bit          timed;
  } sexp_t;

  pexp_t pq[$];
  sexp_t sq[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int occ = 0;
  bit rnd_ready = 0;
  bit gap_en = 0;

  // Reference model: frame position as plain integers
  bit       m_inframe = 0;
  int       m_col = 0;
  int       m_row = 0;
  logic [2:0] m_err = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic void model_beat(input logic [23:0] d, input bit u, input bit l,
                                     input bit clr, input int c);
    logic [2:0] ne;
    pexp_t p;
    sexp_t s;
    ne = '0;
    s.v = {u, l, d};
    s.cyc = c;
    s.timed = !rnd_ready;
    sq.push_back(s);
    if (m_inframe || u) begin
      p.fs = u;
      p.fd = 0;
      if (u) begin
        if (m_inframe && (m_col != 0 || m_row != 0)) ne[2] = 1'b1;
        m_col = 0;
        m_row = 0;
        m_inframe = 1;
      end
      p.col = m_col;
      p.row = m_row;
      p.d = d;
      p.cyc = c + 1;
      if (m_col >= COLS) ne[1] = 1'b1;
      if (l) begin
        if (m_col < COLS - 1) ne[0] = 1'b1;
        if (m_row == ROWS - 1) begin
          p.fd = 1;
          m_inframe = 0;
        end
        m_col = 0;
        m_row++;
      end else if (m_col < 65535) begin
        m_col++;
      end
      pq.push_back(p);
    end
    m_err = clr ? ne : (m_err | ne);
  endfunction

  // Called at posedge+1; returns at posedge+1 after the accepting edge
  task automatic send(input logic [23:0] d, input bit u, input bit l, input bit clr);
    int n;
    bit ok;
    if (gap_en) begin
      repeat ($urandom_range(0, 2)) begin
        s_axis_tvalid = 1'b0;
        @(posedge clk); #1;
      end
    end
    s_axis_tvalid = 1'b1;
    s_axis_tdata = d;
    s_axis_tuser = u;
    s_axis_tlast = l;
    clear_err = clr;
    n = 0;
    ok = 0;
    while (!ok && n < 200) begin
      @(negedge clk);
      if (s_axis_tready) ok = 1;
      else n++;
    end
    if (ok) model_beat(d, u, l, clr, cyc);
    else begin
      checks++;
      errors++;
      $display("FAIL send_timeout actual=tready_low required=accept within 200 cycles");
    end
    @(posedge clk); #1;
    s_axis_tvalid = 1'b0;
    clear_err = 1'b0;
  endtask

  task automatic send_line(input int n, input bit sof, input bit eol);
    for (int i = 0; i < n; i++)
      send(24'($urandom), sof && i == 0, eol && i == n - 1, 1'b0);
  endtask

  task automatic send_frame();
    for (int r = 0; r < ROWS; r++) send_line(COLS, r == 0, 1'b1);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic do_clear();
    clear_err = 1'b1;
    @(posedge clk); #1;
    clear_err = 1'b0;
    m_err = '0;
    idle(1);
    chk("err_after_clear", err_flags, 3'b000);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_pix_en"}, pix_en, 0);
    chk({tag, "_frame_start"}, frame_start, 0);
    chk({tag, "_frame_done"}, frame_done, 0);
    chk({tag, "_err_flags"}, err_flags, 0);
    chk({tag, "_m_tvalid"}, m_axis_tvalid, 0);
    chk({tag, "_pix_col"}, pix_col, 0);
    chk({tag, "_pix_row"}, pix_row, 0);
    chk({tag, "_pix_data"}, pix_data, 0);
    chk({tag, "_s_tready"}, s_axis_tready, 0);
  endtask

  initial forever begin
    @(posedge clk); #1;
    m_axis_tready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Monitor: pops expectations whenever the DUT presents output
  initial begin
    pexp_t p;
    sexp_t s;
    bit stall_prev;
    logic [25:0] pay_prev;
    stall_prev = 0;
    pay_prev = '0;
    forever begin
      @(negedge clk);
      if (pix_en) begin
        if (pq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL pix_unexpected actual col=%0d row=%0d required=no strobe", pix_col, pix_row);
        end else begin
          p = pq.pop_front();
          chk("pix_col", pix_col, p.col);
          chk("pix_row", pix_row, p.row);
          chk("pix_data", pix_data, p.d);
          chk("frame_start", frame_start, p.fs);
          chk("frame_done", frame_done, p.fd);
          chk("pix_latency", cyc, p.cyc);
        end
      end else if (frame_start || frame_done) begin
        checks++;
        errors++;
        $display("FAIL frame_pulse_without_pix actual fs=%0b fd=%0b required=0", frame_start, frame_done);
      end
      if (m_axis_tvalid && m_axis_tready) begin
        if (sq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL stream_unexpected actual=%0h required=no beat", m_axis_tdata);
        end else begin
          s = sq.pop_front();
          chk("stream_beat", {m_axis_tuser, m_axis_tlast, m_axis_tdata}, s.v);
          if (s.timed) chk("stream_latency", cyc, s.cyc + 1);
        end
      end
      if (stall_prev) begin
        chk("axi_hold_valid", m_axis_tvalid, 1);
        chk("axi_hold_payload", {m_axis_tuser, m_axis_tlast, m_axis_tdata}, pay_prev);
      end
      stall_prev = reset_n && m_axis_tvalid && !m_axis_tready;
      pay_prev = {m_axis_tuser, m_axis_tlast, m_axis_tdata};
      if (s_axis_tvalid && s_axis_tready) occ++;
      if (m_axis_tvalid && m_axis_tready) occ--;
      if (!reset_n) occ = 0;
      if (rnd_ready) chk("held_beats_le2", occ <= 2, 1);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("por");
    reset_n = 1'b1;
    idle(1);
    chk("ready_after_reset", s_axis_tready, 1);

    // Clean 4x3 frame with continuous valid
    send_frame();
    idle(3);
    chk("err_clean_frame", err_flags, 3'b000);

    // Beats before SOF are ignored
    send_line(5, 1'b0, 1'b0);
    send_frame();
    idle(3);
    chk("err_pre_sof", err_flags, m_err);

    // Short line 1, long line 2
    send_line(4, 1'b1, 1'b1);
    send_line(3, 1'b0, 1'b1);
    send_line(5, 1'b0, 1'b1);
    idle(3);
    chk("err_short_long", err_flags, 3'b011);
    do_clear();

    // SOF arriving at (2,1)
    send_line(4, 1'b1, 1'b1);
    send_line(2, 1'b0, 1'b0);
    send_frame();
    idle(3);
    chk("err_sof_midframe", err_flags, 3'b100);
    do_clear();

    // tuser and tlast on the same beat
    send(24'($urandom), 1'b1, 1'b1, 1'b0);
    send_line(4, 1'b0, 1'b1);
    send_line(4, 1'b0, 1'b1);
    idle(3);
    chk("err_sof_eol_same", err_flags, 3'b001);

    // clear_err coinciding with a new long-line error: the error wins
    send_line(4, 1'b1, 1'b0);
    send(24'($urandom), 1'b0, 1'b1, 1'b1);
    send_line(4, 1'b0, 1'b1);
    send_line(4, 1'b0, 1'b1);
    idle(3);
    chk("err_clear_vs_new", err_flags, 3'b010);
    do_clear();

    // Randomised valid and downstream ready over 3 frames
    rnd_ready = 1;
    gap_en = 1;
    idle(2);
    repeat (3) send_frame();
    idle(20);
    rnd_ready = 0;
    gap_en = 0;
    idle(5);
    chk("err_random", err_flags, m_err);

    // Reset held low for one cycle in the middle of a line
    send_line(4, 1'b1, 1'b1);
    send_line(2, 1'b0, 1'b0);
    reset_n = 1'b0;
    @(posedge clk); #1;
    check_reset_vals("midreset");
    chk("pq_empty_at_reset", pq.size(), 0);
    sq.delete();
    m_inframe = 0;
    m_col = 0;
    m_row = 0;
    m_err = '0;
    reset_n = 1'b1;
    send_line(3, 1'b0, 1'b0);
    send_frame();
    idle(5);
    chk("err_after_reset", err_flags, 3'b000);

    chk("pix_queue_drained", pq.size(), 0);
    chk("stream_queue_drained", sq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
